// File: rtl/lcd_peak_writer_if.sv
// lcd_peak_writer_if
//   Avalon-MM write path between lcd_peak_writer (master) and the character
//   LCD controller slave.
//   address     : 0 = instruction register, 1 = data register
//   chipselect  : slave select
//   write       : write strobe
//   read        : read strobe (never asserted by this master)
//   writedata   : command or ASCII byte
//   waitrequest : slave stall, holds the current transfer while high
interface lcd_peak_writer_if;
    logic       address;
    logic       chipselect;
    logic       write;
    logic       read;
    logic [7:0] writedata;
    logic       waitrequest;

    modport master (
        output address, chipselect, write, read, writedata,
        input  waitrequest
    );

    modport slave (
        input  address, chipselect, write, read, writedata,
        output waitrequest
    );
endinterface

// File: rtl/lcd_peak_writer.sv
// lcd_peak_writer
//   Turns the FFT peak bin into a " ddddd Hz" readout on the character LCD.
//   Each peak_valid strobe is captured in a one-deep pending register; when
//   idle the bin is scaled to Hz, converted to decimal (double-dabble) and
//   sent as a cursor-set command followed by eight character writes.
//   clk         : system clock
//   reset       : asynchronous, active-high reset
//   peak_k      : peak bin index, valid with peak_valid
//   peak_valid  : single-cycle strobe, newest value wins
//   lcd         : Avalon-MM master port towards the LCD controller
//   busy        : high whenever the sequencer is not idle
//   update_done : one-cycle pulse after the last byte is accepted
module lcd_peak_writer #(
    parameter int unsigned HZ_PER_BIN_Q8  = 12000,
    parameter logic [6:0]  LCD_COL        = 7'h40,
    parameter int unsigned HOLDOFF_CYCLES = 5_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        peak_k,
    input  logic              peak_valid,
    lcd_peak_writer_if.master lcd,
    output logic              busy,
    output logic              update_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCALE,
        S_BCD,
        S_XFER,
        S_GAP,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  pend_k_q, pend_k_d;
    logic        pend_v_q, pend_v_d;
    logic [9:0]  k_q, k_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] hold_q, hold_d;
    logic        addr_q, addr_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [41:0] prod;
    logic [33:0] hz_wide;
    logic [15:0] hz_sat;
    logic [19:0] adj;
    logic        consume;
    logic        drive;

    // Byte presented for a given sequence index; leading zeros of d4..d1
    // are shown as spaces, d0 always prints.
    function automatic logic [7:0] lcd_byte(input logic [3:0] idx, input logic [19:0] bcd);
        logic b4, b3, b2, b1;
        b4 = (bcd[19:16] == 4'd0);
        b3 = b4 && (bcd[15:12] == 4'd0);
        b2 = b3 && (bcd[11:8] == 4'd0);
        b1 = b2 && (bcd[7:4] == 4'd0);
        case (idx)
            4'd0:    lcd_byte = 8'h80 | {1'b0, LCD_COL};
            4'd1:    lcd_byte = b4 ? 8'h20 : {4'h3, bcd[19:16]};
            4'd2:    lcd_byte = b3 ? 8'h20 : {4'h3, bcd[15:12]};
            4'd3:    lcd_byte = b2 ? 8'h20 : {4'h3, bcd[11:8]};
            4'd4:    lcd_byte = b1 ? 8'h20 : {4'h3, bcd[7:4]};
            4'd5:    lcd_byte = {4'h3, bcd[3:0]};
            4'd6:    lcd_byte = 8'h20;
            4'd7:    lcd_byte = 8'h48;
            4'd8:    lcd_byte = 8'h7A;
            default: lcd_byte = 8'h20;
        endcase
    endfunction

    // Bin to Hz: truncating Q8 scale, saturated to 16 bits.
    always_comb begin
        prod    = 42'(k_q) * 42'(HZ_PER_BIN_Q8);
        hz_wide = 34'(prod >> 8);
        hz_sat  = (|hz_wide[33:16]) ? 16'hFFFF : hz_wide[15:0];
    end

    // Double-dabble correction: add 3 to every digit of 5 or more before shifting.
    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        consume   = 1'b0;
        drive     = 1'b0;
        done_d    = 1'b0;
        addr_d    = 1'b0;
        cs_d      = 1'b0;
        wr_d      = 1'b0;
        wdata_d   = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (pend_v_q) begin
                    k_d     = pend_k_q;
                    consume = 1'b1;
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                bin_d     = hz_sat;
                bcd_d     = '0;
                bit_cnt_d = '0;
                state_d   = S_BCD;
            end
            S_BCD: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                bit_cnt_d      = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    idx_d   = '0;
                    drive   = 1'b1;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (lcd.waitrequest) begin
                    drive = 1'b1;
                end else if (idx_q == 4'd8) begin
                    done_d  = 1'b1;
                    hold_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                drive   = 1'b1;
                state_d = S_XFER;
            end
            S_HOLD: begin
                if ((hold_q + 32'd1) >= HOLDOFF_CYCLES) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state:
        // the bus request appears in the first XFER cycle and stays put
        // while the slave stalls.
        if (drive) begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = (idx_d != 4'd0);
            wdata_d = lcd_byte(idx_d, bcd_d);
        end

        busy_d = (state_d != S_IDLE);

        // A new strobe always wins over a consume on the same edge.
        pend_k_d = peak_valid ? peak_k : pend_k_q;
        if (peak_valid) begin
            pend_v_d = 1'b1;
        end else if (consume) begin
            pend_v_d = 1'b0;
        end else begin
            pend_v_d = pend_v_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pend_k_q  <= '0;
            pend_v_q  <= 1'b0;
            k_q       <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            addr_q    <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_k_q  <= pend_k_d;
            pend_v_q  <= pend_v_d;
            k_q       <= k_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign lcd.address    = addr_q;
    assign lcd.chipselect = cs_q;
    assign lcd.write      = wr_q;
    assign lcd.read       = 1'b0;
    assign lcd.writedata  = wdata_q;
    assign busy           = busy_q;
    assign update_done    = done_q;

endmodule

// File: tb/tb_lcd_peak_writer.sv
module tb_lcd_peak_writer;

    localparam int unsigned HOLD = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] peak_k = '0;
    logic       peak_valid = 1'b0;
    logic       busy;
    logic       update_done;

    lcd_peak_writer_if bus();

    lcd_peak_writer #(
        .HZ_PER_BIN_Q8(12000),
        .LCD_COL(7'h40),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .peak_k(peak_k),
        .peak_valid(peak_valid),
        .lcd(bus.master),
        .busy(busy),
        .update_done(update_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] acc_q[$];
    int acc_start[$];
    int upd_cnt = 0;
    int read_seen = 0;
    int drop_cnt = 0;
    int stall = 0;
    bit in_req = 1'b0;
    int held = 0;
    int byte_start = 0;
    logic [8:0] ref_byte = '0;

    typedef struct {
        logic [9:0]  k;
        int          stall;
        logic [39:0] digs;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accepted transfers, recorded on the edge that completes them.
    always @(posedge clk) begin
        if (!reset && bus.chipselect && bus.write && !bus.waitrequest) begin
            acc_q.push_back({bus.address, bus.writedata});
            acc_start.push_back(byte_start);
        end
        cyc <= cyc + 1;
    end

    // Slave model: stalls each request for 'stall' cycles, checks the
    // request stays stable while stalled.
    always @(negedge clk) begin
        if (reset) begin
            bus.waitrequest = 1'b0;
            in_req = 1'b0;
        end else if (bus.chipselect && bus.write) begin
            if (!in_req) begin
                in_req = 1'b1;
                byte_start = cyc;
                ref_byte = {bus.address, bus.writedata};
                held = 0;
            end else begin
                check("hold_stable", 32'({bus.address, bus.writedata}), 32'(ref_byte));
            end
            if (held < stall) begin
                bus.waitrequest = 1'b1;
                held++;
            end else begin
                bus.waitrequest = 1'b0;
                in_req = 1'b0;
            end
        end else begin
            if (in_req) drop_cnt++;
            in_req = 1'b0;
            bus.waitrequest = 1'b0;
        end
        if (update_done && !reset) upd_cnt++;
        if (bus.read) read_seen++;
    end

    function automatic logic [8:0] exp_byte(input int i, input logic [39:0] digs);
        case (i)
            0:       return 9'h0C0;
            6:       return 9'h120;
            7:       return 9'h148;
            8:       return 9'h17A;
            default: return {1'b1, digs[8*(5-i) +: 8]};
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe(input logic [9:0] k, output int c0);
        @(negedge clk);
        peak_k = k;
        peak_valid = 1'b1;
        @(negedge clk);
        peak_valid = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_update(input string name, output int ucyc);
        bit seen;
        seen = 1'b0;
        ucyc = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (update_done) begin
                seen = 1'b1;
                ucyc = cyc;
            end
        end
        check({name, "_update_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        check({name, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic check_seq(input string name, input int base, input logic [39:0] digs);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s_byte%0d", name, i), 32'(acc_q[base+i]), 32'(exp_byte(i, digs)));
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int c0, u;
        string nm;
        nm = $sformatf("vec%0d_k%0d", n, v.k);
        acc_q.delete();
        acc_start.delete();
        stall = v.stall;
        strobe(v.k, c0);
        wait_update(nm, u);
        check({nm, "_count"}, 32'(acc_q.size()), 32'd9);
        check_seq(nm, 0, v.digs);
        check({nm, "_first_write_latency"}, 32'(acc_start[0] - c0), 32'd18);
        check({nm, "_done_after_first"}, 32'(u - acc_start[0]), 32'(17 + 9 * v.stall));
        wait_idle(nm);
    endtask

    initial begin
        int c0, u, u2, base_upd;
        bit found;

        //               k     stall  d4    d3    d2    d1    d0
        vecs[0] = '{10'd0,    0, {8'h20, 8'h20, 8'h20, 8'h20, 8'h30}};
        vecs[1] = '{10'd64,   0, {8'h20, 8'h33, 8'h30, 8'h30, 8'h30}};
        vecs[2] = '{10'd1023, 3, {8'h34, 8'h37, 8'h39, 8'h35, 8'h33}};
        vecs[3] = '{10'd1,    0, {8'h20, 8'h20, 8'h20, 8'h34, 8'h36}};
        vecs[4] = '{10'd5,    1, {8'h20, 8'h20, 8'h32, 8'h33, 8'h34}};
        vecs[5] = '{10'd10,   0, {8'h20, 8'h20, 8'h34, 8'h36, 8'h38}};
        vecs[6] = '{10'd213,  2, {8'h20, 8'h39, 8'h39, 8'h38, 8'h34}};
        vecs[7] = '{10'd214,  0, {8'h31, 8'h30, 8'h30, 8'h33, 8'h31}};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_chipselect", 32'(bus.chipselect), 32'd0);
        check("rst_write", 32'(bus.write), 32'd0);
        check("rst_writedata", 32'(bus.writedata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_update_done", 32'(update_done), 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_no_writes", 32'(acc_q.size()), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Coalescing: 10, 20, 30 arrive during a transfer; only 30 follows.
        acc_q.delete();
        acc_start.delete();
        stall = 0;
        base_upd = upd_cnt;
        strobe(10'd64, c0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (acc_q.size() >= 1) found = 1'b1;
        end
        check("coal_xfer_started", 32'(found), 32'd1);
        strobe(10'd10, c0);
        strobe(10'd20, c0);
        strobe(10'd30, c0);
        wait_update("coal_first", u);
        wait_update("coal_second", u2);
        repeat (60) tick();
        check("coal_updates", 32'(upd_cnt - base_upd), 32'd2);
        check("coal_count", 32'(acc_q.size()), 32'd18);
        check_seq("coal_a", 0, {8'h20, 8'h33, 8'h30, 8'h30, 8'h30});
        check_seq("coal_b", 9, {8'h20, 8'h31, 8'h34, 8'h30, 8'h36});
        check("coal_after_hold", 32'(acc_start[9] - u), 32'd28);

        // Hold-off: strobe 2 cycles into HOLD is served only after HOLD ends.
        acc_q.delete();
        acc_start.delete();
        strobe(10'd5, c0);
        wait_update("ho_first", u);
        for (int i = 0; i < int'(HOLD); i++) begin
            check($sformatf("ho_busy_%0d", i), 32'(busy), 32'd1);
            if (i == 2) begin
                peak_k = 10'd1;
                peak_valid = 1'b1;
            end
            if (i == 3) peak_valid = 1'b0;
            tick();
        end
        check("ho_busy_after_hold", 32'(busy), 32'd0);
        wait_update("ho_second", u2);
        check("ho_first_write_delay", 32'(acc_start[9] - u), 32'd28);
        check_seq("ho_b", 9, {8'h20, 8'h20, 8'h20, 8'h34, 8'h36});
        wait_idle("ho");

        // Reset while byte idx 3 is on the bus.
        acc_q.delete();
        acc_start.delete();
        base_upd = upd_cnt;
        strobe(10'd64, c0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (bus.chipselect && acc_q.size() == 3) found = 1'b1;
        end
        check("mid_idx3_reached", 32'(found), 32'd1);
        check("mid_idx3_data", 32'({bus.address, bus.writedata}), 32'h130);
        reset = 1'b1;
        #1;
        check("mid_rst_chipselect", 32'(bus.chipselect), 32'd0);
        check("mid_rst_write", 32'(bus.write), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_writedata", 32'(bus.writedata), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (40) tick();
        check("mid_no_resume_writes", 32'(acc_q.size()), 32'd3);
        check("mid_no_resume_busy", 32'(busy), 32'd0);
        check("mid_no_update", 32'(upd_cnt - base_upd), 32'd0);

        check("read_never", 32'(read_seen), 32'd0);
        check("cs_never_dropped_while_stalled", 32'(drop_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
